egress_arbiter: RTL and testbench

Frame-granular round-robin arbiter that shares one egress AXI-Stream port among `NUM_PORTS` switch requesters. A grant is issued only at frame boundaries and held until the granted requester completes a `tlast` handshake, so frames are never interleaved. It sits between the per-ingress requesters and the switch egress, and passes data through with zero added latency once a grant is held. An optional watchdog reclaims the egress port from a requester that stops presenting data mid-frame.

---
 rtl/egress_arbiter.sv | 131 +++++++++++++
 tb/tb_egress_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI-Stream egress among NUM_PORTS requesters.
// Optional watchdog that reclaims a stalled grant: define EGRESS_ARB_WATCHDOG_EN.
module egress_arbiter #(
  parameter int NUM_PORTS         = 4,
  parameter int DATA_WIDTH        = 16,
  parameter int TIMEOUT_CTR_WIDTH = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_tvalid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_tdata,
  input  logic [NUM_PORTS-1:0]             req_tlast,
  output logic [NUM_PORTS-1:0]             req_tready,
  output logic                             egress_tvalid,
  output logic [DATA_WIDTH-1:0]            egress_tdata,
  output logic                             egress_tlast,
  input  logic                             egress_tready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             busy,
  output logic                             abort
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_PORTS - 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  if (NUM_PORTS < 2 || TIMEOUT_CTR_WIDTH < 1) begin : g_cfg_check
    $error("egress_arbiter: NUM_PORTS must be >= 2 and TIMEOUT_CTR_WIDTH >= 1");
  end

  logic [0:0]           state;
  logic [IDX_W-1:0]     last_grant;
  logic [NUM_PORTS-1:0] grant_q;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand;
  logic                 egress_hs;
  logic                 frame_done;
  logic                 wd_fire;

  // Search starts one past the last grant and wraps, so the last winner ranks lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_PORTS);
      if (!pick_found && req_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // While LOCKED, last_grant is the owner index, so it drives the pass-through mux directly.
  always_comb begin
    req_tready    = '0;
    egress_tvalid = 1'b0;
    egress_tdata  = '0;
    egress_tlast  = 1'b0;
    if (state == ST_LOCKED) begin
      egress_tvalid          = req_tvalid[last_grant];
      egress_tdata           = req_tdata[32'(last_grant)*DATA_WIDTH +: DATA_WIDTH];
      egress_tlast           = req_tlast[last_grant];
      req_tready[last_grant] = egress_tready;
    end
  end

  assign egress_hs  = egress_tvalid & egress_tready;
  assign frame_done = egress_hs & egress_tlast;
  assign busy       = (state == ST_LOCKED);
  assign grant      = grant_q;

`ifdef EGRESS_ARB_WATCHDOG_EN
  localparam int WD_W = TIMEOUT_CTR_WIDTH + 1;

  logic [WD_W-1:0] wd_ctr;
  logic [WD_W-1:0] wd_inc;
  logic            abort_q;

  // Only stalls with tvalid low count; downstream backpressure holds the counter.
  assign wd_inc  = wd_ctr + WD_W'(1);
  assign wd_fire = busy & ~egress_tvalid & wd_inc[TIMEOUT_CTR_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_ctr  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= wd_fire & ~frame_done;
      if (!busy || egress_hs || wd_fire) begin
        wd_ctr <= '0;
      end else if (!egress_tvalid) begin
        wd_ctr <= wd_inc;
      end
    end
  end

  assign abort = abort_q;
`else
  assign wd_fire = 1'b0;
  assign abort   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      last_grant <= LAST_INIT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q    <= NUM_PORTS'(1) << pick_idx;
            last_grant <= pick_idx;
            state      <= ST_LOCKED;
          end
        end
        default: begin
          // A watchdog revoke keeps last_grant, leaving the aborted port lowest priority.
          if (frame_done || wd_fire) begin
            grant_q <= '0;
            state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_egress_arbiter.sv
// Self-checking bench for egress_arbiter: vector table, directed frame sequences, random vs. model.
module tb_egress_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_tvalid;
  logic [N*DW-1:0] req_tdata;
  logic [N-1:0]    req_tlast;
  logic [N-1:0]    req_tready;
  logic            egress_tvalid;
  logic [DW-1:0]   egress_tdata;
  logic            egress_tlast;
  logic            egress_tready;
  logic [N-1:0]    grant;
  logic            busy;
  logic            abort;

  egress_arbiter #(
    .NUM_PORTS(N),
    .DATA_WIDTH(DW),
    .TIMEOUT_CTR_WIDTH(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_tvalid(req_tvalid),
    .req_tdata(req_tdata),
    .req_tlast(req_tlast),
    .req_tready(req_tready),
    .egress_tvalid(egress_tvalid),
    .egress_tdata(egress_tdata),
    .egress_tlast(egress_tlast),
    .egress_tready(egress_tready),
    .grant(grant),
    .busy(busy),
    .abort(abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    req_tvalid    = '0;
    req_tlast     = '0;
    req_tdata     = '0;
    egress_tready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'(16'hA000 + i * 16'h0111);
  endfunction

  function automatic int idx_of(input logic [N-1:0] oh);
    int r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic [27:0] pack_act();
    return {grant, busy, abort, egress_tvalid, egress_tlast, egress_tdata, req_tready};
  endfunction

  // Reference model: owner index (-1 when free), round-robin pointer, stall count.
  int m_owner, m_ptr, m_stall;
  bit m_abort;

  function automatic logic [27:0] model_out();
    logic [N-1:0]  g  = '0;
    logic [N-1:0]  tr = '0;
    logic          tv = 1'b0;
    logic          tl = 1'b0;
    logic [DW-1:0] d  = '0;
    if (m_owner >= 0) begin
      g[m_owner]  = 1'b1;
      tv          = req_tvalid[m_owner];
      tl          = req_tlast[m_owner];
      d           = req_tdata[m_owner*DW +: DW];
      tr[m_owner] = egress_tready;
    end
    return {g, (m_owner >= 0), m_abort, tv, tl, d, tr};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_stall = 0;
    m_abort = 1'b0;
  endtask

  task automatic model_step();
    bit hs;
    int p;
    if (reset) begin
      model_reset();
      return;
    end
    m_abort = 1'b0;
    if (m_owner < 0) begin
      m_stall = 0;
      for (int k = 1; k <= N; k++) begin
        p = (m_ptr + k) % N;
        if (req_tvalid[p]) begin
          m_owner = p;
          m_ptr   = p;
          break;
        end
      end
    end else begin
      hs = req_tvalid[m_owner] && egress_tready;
      if (hs && req_tlast[m_owner]) begin
        m_owner = -1;
        m_stall = 0;
      end else if (hs) begin
        m_stall = 0;
      end else if (!req_tvalid[m_owner]) begin
        m_stall++;
`ifdef EGRESS_ARB_WATCHDOG_EN
        if (m_stall == (1 << TW)) begin
          m_abort = 1'b1;
          m_owner = -1;
          m_stall = 0;
        end
`endif
      end
    end
  endtask

  typedef struct packed {
    logic         rst;
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         rdy;
    logic [N-1:0] g;
    logic         tv;
    logic         tl;
    logic [N-1:0] tr;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            bc [N];
    int            nb, last_end, oh_err;
    int            bc2, n2, end_cyc, g0_cyc, err;
    int            bad, nhs;
    logic [DW-1:0] exp_d;

    //            rst  valid    last     rdy   grant    tv    tl    tready
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010};
    tbl[7]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 4'b1000};
    tbl[12] = '{1'b0, 4'b0111, 4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000};
    tbl[13] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000};
    tbl[14] = '{1'b0, 4'b0111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[15] = '{1'b0, 4'b0111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001};
    tbl[16] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001};
    tbl[17] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[18] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001};

    // Vector table
    do_reset();
    for (int i = 0; i < N; i++) req_tdata[i*DW +: DW] = pat(i);
    for (int r = 0; r < 19; r++) begin
      reset         = tbl[r].rst;
      req_tvalid    = tbl[r].v;
      req_tlast     = tbl[r].l;
      egress_tready = tbl[r].rdy;
      #1;
      exp_d = (tbl[r].g == '0) ? '0 : pat(idx_of(tbl[r].g));
      check($sformatf("vec%0d", r), 64'(pack_act()),
            64'({tbl[r].g, |tbl[r].g, 1'b0, tbl[r].tv, tbl[r].tl, exp_d, tbl[r].tr}));
      tick();
    end
    reset = 1'b0;

    // All ports contending with 3-beat frames: order 0,1,2,3,0, one idle cycle between frames
    do_reset();
    bc = '{default: 0};
    nb = 0; last_end = -100; oh_err = 0;
    for (int c = 0; c < 200 && nb < 15; c++) begin
      for (int i = 0; i < N; i++) begin
        req_tvalid[i]          = 1'b1;
        req_tlast[i]           = (bc[i] == 2);
        req_tdata[i*DW +: DW]  = 16'(i * 256 + bc[i]);
      end
      egress_tready = 1'b1;
      #1;
      if (busy != $onehot(grant)) oh_err++;
      if (egress_tvalid && egress_tready) begin
        check("rr_beat", 64'(egress_tdata), 64'(((nb / 3) % N) * 256 + (nb % 3)));
        if (nb % 3 == 0 && nb > 0) check("rr_gap", 64'(c - last_end), 64'(2));
        if (nb % 3 == 2) last_end = c;
        nb++;
      end
      for (int i = 0; i < N; i++)
        if (req_tvalid[i] && req_tready[i]) bc[i] = (bc[i] == 2) ? 0 : bc[i] + 1;
      tick();
    end
    check("rr_beat_count", 64'(nb), 64'(15));
    check("rr_onehot", 64'(oh_err), 64'(0));

    // Port 0 requests while port 2 is mid-frame
    do_reset();
    bc2 = 0; n2 = 0; end_cyc = -1; g0_cyc = -1; err = 0;
    for (int c = 0; c < 60 && g0_cyc < 0; c++) begin
      req_tvalid[2]           = (bc2 < 3);
      req_tlast[2]            = (bc2 == 2);
      req_tdata[2*DW +: DW]   = 16'(16'h2000 + bc2);
      req_tvalid[0]           = (bc2 > 0);
      req_tlast[0]            = 1'b1;
      req_tdata[0 +: DW]      = 16'h0F0F;
      egress_tready           = 1'b1;
      #1;
      if (grant == 4'b0001) begin
        g0_cyc = c;
      end else begin
        if (req_tready[0]) err++;
        if (req_tvalid[2] && req_tready[2]) begin
          n2++;
          if (req_tlast[2]) end_cyc = c;
          bc2++;
        end
      end
      tick();
    end
    check("mid_p2_beats", 64'(n2), 64'(3));
    check("mid_p0_ready_low", 64'(err), 64'(0));
    check("mid_p0_grant_gap", 64'(g0_cyc - end_cyc), 64'(2));

    // Long downstream backpressure mid-frame: no abort, beat held stable
    do_reset();
    req_tvalid = 4'b0010; req_tlast = '0;
    req_tdata[DW +: DW] = 16'h1111;
    egress_tready = 1'b1;
    tick();
    #1;
    check("stall_first_beat", 64'({grant, egress_tvalid}), 64'({4'b0010, 1'b1}));
    tick();
    req_tdata[DW +: DW] = 16'h2222;
    req_tlast[1] = 1'b1;
    egress_tready = 1'b0;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      #1;
      if (abort || !egress_tvalid || egress_tdata !== 16'h2222 || !egress_tlast ||
          grant !== 4'b0010 || req_tready !== 4'b0000) bad++;
      tick();
    end
    check("stall_hold_stable", 64'(bad), 64'(0));
    egress_tready = 1'b1;
    #1;
    check("stall_release", 64'({egress_tvalid, egress_tlast, req_tready}), 64'({1'b1, 1'b1, 4'b0010}));
    tick();
    req_tvalid = '0;
    #1;
    check("stall_done_idle", 64'({busy, grant}), 64'(0));
    tick();

    // Granted port 1 drops tvalid mid-frame while port 2 waits
    do_reset();
    req_tvalid = 4'b0110; req_tlast = '0;
    req_tdata[DW +: DW]   = 16'h1234;
    req_tdata[2*DW +: DW] = 16'h5678;
    egress_tready = 1'b1;
    tick();
    #1;
    check("wd_grant_p1", 64'(grant), 64'(4'b0010));
    tick();
    req_tvalid[1] = 1'b0;
`ifdef EGRESS_ARB_WATCHDOG_EN
    begin : wd_on
      int stalls;
      bit found;
      stalls = 0; found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
        #1;
        if (abort) begin
          found = 1'b1;
        end else begin
          if (busy && grant == 4'b0010) stalls++;
          tick();
        end
      end
      check("wd_abort_seen", 64'(found), 64'(1));
      check("wd_stall_cycles", 64'(stalls), 64'(1 << TW));
      check("wd_abort_released", 64'({busy, grant}), 64'(0));
      tick();
      #1;
      check("wd_regrant_p2", 64'({abort, grant}), 64'({1'b0, 4'b0100}));
    end
`else
    begin : wd_off
      int aborts;
      aborts = 0;
      for (int c = 0; c < 600; c++) begin
        #1;
        if (abort) aborts++;
        tick();
      end
      #1;
      check("nowd_no_abort", 64'(aborts), 64'(0));
      check("nowd_grant_held", 64'(grant), 64'(4'b0010));
    end
`endif

    // Single-beat frames on port 3 only: one frame every 2 cycles
    do_reset();
    req_tvalid = 4'b1000; req_tlast = 4'b1000;
    req_tdata[3*DW +: DW] = 16'h3333;
    egress_tready = 1'b1;
    nhs = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (egress_tvalid && egress_tready && egress_tlast && egress_tdata == 16'h3333) nhs++;
      tick();
    end
    check("single_beat_rate", 64'(nhs), 64'(10));

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(199) == 0);
      for (int i = 0; i < N; i++) begin
        req_tvalid[i]         = ($urandom_range(9) < 7);
        req_tlast[i]          = ($urandom_range(9) < 3);
        req_tdata[i*DW +: DW] = 16'($urandom);
      end
      egress_tready = ($urandom_range(3) != 0);
      #1;
      check("rand_cycle", 64'(pack_act()), 64'(model_out()));
      model_step();
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
